frame_dispatch: RTL



---
 rtl/dispatch_pkg.sv | 36 +++
 rtl/frame_dispatch_if.sv | 30 +++
 rtl/word_serializer.sv | 59 +++++
 rtl/frame_dispatch.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared layout for the 140-bit frame FIFO entry and the
// dispatch FSM state encoding. The parser stage imports this too, so the
// entry layout {data_128, data_ch, data_count} lives here only.
//
// Build option: DISPATCH_PARITY_EN (used by word_serializer/frame_dispatch).
package dispatch_pkg;

    localparam int FRAME_W   = 140;
    localparam int DATA_W    = 128;
    localparam int CH_W      = 8;
    localparam int CNT_W     = 4;
    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = DATA_W / WORD_W;

    // First member is the MSB: data at [139:12], ch at [11:4], count at [3:0].
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic [CNT_W-1:0]  count;
    } frame_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPTURE,
        ST_SHIFT,
        ST_GAP
    } dispatch_state_t;

    // Select payload word idx; word 0 sits at data[15:0].
    function automatic logic [WORD_W-1:0] pick_word(input logic [DATA_W-1:0] data,
                                                    input logic [2:0]        idx);
        return data[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/frame_dispatch_if.sv
// frame_dispatch_if: bundles the frame FIFO read side and the serial lane
// outputs of frame_dispatch.
//   fifo_empty, data_from_fifo : FIFO -> dispatcher
//   fifo_r_enable              : dispatcher -> FIFO read strobe
//   data_out, data_valid       : per-lane serial data / valid
//   busy, len_err, ch_err      : status
// modport master: the dispatcher side. modport slave: FIFO/pin side.
interface frame_dispatch_if;
    import dispatch_pkg::*;

    logic               fifo_empty;
    logic               fifo_r_enable;
    logic [FRAME_W-1:0] data_from_fifo;
    logic [CH_W-1:0]    data_out;
    logic [CH_W-1:0]    data_valid;
    logic               busy;
    logic               len_err;
    logic               ch_err;

    modport master (
        input  fifo_empty, data_from_fifo,
        output fifo_r_enable, data_out, data_valid, busy, len_err, ch_err
    );

    modport slave (
        output fifo_empty, data_from_fifo,
        input  fifo_r_enable, data_out, data_valid, busy, len_err, ch_err
    );

endinterface

// File: rtl/word_serializer.sv
// word_serializer: loads one 16-bit word and presents it MSB-first, one bit
// per shift cycle. With DISPATCH_PARITY_EN defined a 17th bit carrying the
// XOR of the word follows bit 0.
//   clk_in, rst_n : clock, async active-low reset
//   load, word    : load a new word (wins over shift)
//   shift         : advance to the next bit
//   bit_out       : current serial bit
//   last_bit      : current bit is the final one of this word
module word_serializer
    import dispatch_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    output logic              bit_out,
    output logic              last_bit
);

`ifdef DISPATCH_PARITY_EN
    localparam logic [4:0] FIRST_CNT = 5'd16;
`else
    localparam logic [4:0] FIRST_CNT = 5'd15;
`endif

    logic [WORD_W-1:0] sr;
    logic [4:0]        bit_cnt;

`ifdef DISPATCH_PARITY_EN
    logic par;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)    par <= 1'b0;
        else if (load) par <= ^word;
    end

    // bit_cnt==0 is the parity slot; the data bits occupy counts 16..1.
    assign bit_out = (bit_cnt == 5'd0) ? par : sr[WORD_W-1];
`else
    assign bit_out = sr[WORD_W-1];
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= word;
            bit_cnt <= FIRST_CNT;
        end else if (shift && bit_cnt != 5'd0) begin
            sr      <= {sr[WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - 5'd1;
        end
    end

    assign last_bit = (bit_cnt == 5'd0);

endmodule

// File: rtl/frame_dispatch.sv
// frame_dispatch: drains the frame FIFO, validates each entry and serialises
// its payload words (highest index first, MSB-first) onto every lane set in
// the entry's channel mask.
//   clk_in, rst_n : clock, async active-low reset
//   bus (master)  : fifo_empty/data_from_fifo in; fifo_r_enable, data_out,
//                   data_valid, busy, len_err, ch_err out
// Parameters: LANES (mask width), MAX_WORDS (largest legal count),
// GAP_CYCLES (idle cycles after each frame, 0..15).
// Build option: DISPATCH_PARITY_EN appends an even-parity bit per word.
module frame_dispatch
    import dispatch_pkg::*;
#(
    parameter int LANES      = CH_W,
    parameter int MAX_WORDS  = 8,
    parameter int GAP_CYCLES = 2
) (
    input logic              clk_in,
    input logic              rst_n,
    frame_dispatch_if.master bus
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    dispatch_state_t   state;
    frame_entry_t      entry_in;
    logic [DATA_W-1:0] payload;
    logic [LANES-1:0]  mask;
    logic [2:0]        word_idx;
    logic [3:0]        gap_cnt;
    logic              rd_en, len_err_q, ch_err_q;

    logic              len_bad, ch_bad;
    logic              ser_load, ser_bit, ser_last;
    logic [WORD_W-1:0] ser_word;

    assign entry_in = bus.data_from_fifo;
    assign len_bad  = (entry_in.count == '0) || (int'(entry_in.count) > MAX_WORDS);
    assign ch_bad   = (entry_in.ch == '0);

    // The first word goes straight from the FIFO bus into the serializer on
    // the capture edge, so the first payload bit appears the next cycle.
    // Later words come from the captured payload as each word finishes.
    always_comb begin
        ser_load = 1'b0;
        ser_word = pick_word(payload, word_idx - 3'd1);
        if (state == ST_CAPTURE) begin
            ser_load = !len_bad && !ch_bad;
            ser_word = pick_word(entry_in.data, 3'(entry_in.count - 4'd1));
        end else if (state == ST_SHIFT) begin
            ser_load = ser_last && (word_idx != 3'd0);
        end
    end

    word_serializer u_ser (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (ser_load),
        .shift    (state == ST_SHIFT),
        .word     (ser_word),
        .bit_out  (ser_bit),
        .last_bit (ser_last)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            payload   <= '0;
            mask      <= '0;
            word_idx  <= '0;
            gap_cnt   <= '0;
            rd_en     <= 1'b0;
            len_err_q <= 1'b0;
            ch_err_q  <= 1'b0;
        end else begin
            rd_en     <= 1'b0;
            len_err_q <= 1'b0;
            ch_err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!bus.fifo_empty) begin
                        state <= ST_REQ;
                        rd_en <= 1'b1;
                    end
                end
                // fifo_empty is not re-checked: the read has been issued.
                ST_REQ: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    payload  <= entry_in.data;
                    mask     <= entry_in.ch;
                    word_idx <= 3'(entry_in.count - 4'd1);
                    // Length error outranks channel error.
                    if (len_bad) begin
                        len_err_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (ch_bad) begin
                        ch_err_q <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_last) begin
                        if (word_idx == 3'd0) begin
                            if (GAP_CYCLES == 0) begin
                                state <= ST_IDLE;
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= GAP_LOAD;
                            end
                        end else begin
                            word_idx <= word_idx - 3'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) state <= ST_IDLE;
                    else                 gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Lane outputs decode registered state only, so reset clears them at once.
    assign bus.data_out      = (state == ST_SHIFT) ? ({LANES{ser_bit}} & mask) : '0;
    assign bus.data_valid    = (state == ST_SHIFT) ? mask : '0;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.fifo_r_enable = rd_en;
    assign bus.len_err       = len_err_q;
    assign bus.ch_err        = ch_err_q;

endmodule
